// File: rtl/usr_pkg.sv
// Shared types for the burst-capable universal shift register:
// operation codes, controller states and the burst-eligibility test.
package usr_pkg;

  // Operation select; codes 0..3 keep the legacy 2-bit encoding
  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_LOAD = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  // Burst controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only real movement modes may be repeated autonomously; HOLD, LOAD and
  // the reserved code make no sense as a burst and fall back to single step.
  function automatic logic is_burst_mode(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_if.sv
// Driver/monitor bus for usr_burst: the master side drives control and
// data, the slave side (the register) returns contents and burst status.
interface usr_if
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             shift_en;
  mode_e            mode;
  logic [WIDTH-1:0] data_in;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] out;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output shift_en, mode, data_in, sin_l, sin_r, start, count,
    input  out, sout_l, sout_r, busy, done
  );

  modport slave (
    input  shift_en, mode, data_in, sin_l, sin_r, start, count,
    output out, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/usr_step.sv
// Combinational next-value function of the register for one operation.
// Shared by the single-step path and the burst path so both behave alike.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  // Select the shifted, rotated or loaded value; unknown codes hold
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHL:  nxt = {cur[WIDTH-2:0], sin_r};
      MODE_SHR:  nxt = {sin_l, cur[WIDTH-1:1]};
      MODE_LOAD: nxt = data_in;
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/usr_burst.sv
// Parametrised universal shift register with an autonomous burst mode.
// A burst latches its mode and clamped length, shifts once per cycle while
// busy, then pulses done for one cycle; DONE accepts inputs like IDLE.
module usr_burst
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic  clk,
  input logic  clr,
  usr_if.slave bus
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  state_e           state;
  mode_e            run_mode;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] reg_q;
  logic             busy_q;
  logic             done_q;
  mode_e            step_mode;
  logic [WIDTH-1:0] step_nxt;
  logic [CNT_W-1:0] clamped;

  // While running only the latched mode matters; otherwise the live mode
  assign step_mode = (state == ST_RUN) ? run_mode : bus.mode;
  assign clamped   = (bus.count > WIDTH_CNT) ? WIDTH_CNT : bus.count;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .cur     (reg_q),
    .mode    (step_mode),
    .data_in (bus.data_in),
    .sin_l   (bus.sin_l),
    .sin_r   (bus.sin_r),
    .nxt     (step_nxt)
  );

  // Controller, burst down-counter and register with registered busy/done
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      run_mode  <= MODE_HOLD;
      remaining <= '0;
      reg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          reg_q     <= step_nxt;
          remaining <= remaining - ONE_CNT;
          if (remaining == ONE_CNT) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        default: begin
          if (bus.start && is_burst_mode(bus.mode)) begin
            run_mode  <= bus.mode;
            remaining <= clamped;
            if (clamped == '0) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            if (bus.shift_en) begin
              reg_q <= step_nxt;
            end
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.out    = reg_q;
  assign bus.sout_l = reg_q[WIDTH-1];
  assign bus.sout_r = reg_q[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: doc/usr_burst.md
Name: usr_burst

Overview:
Parametrised successor to the 4-bit universal shift register. It adds a configurable width, serial in/out on both ends, rotate and arithmetic-shift modes, and an autonomous burst mode. In burst mode the register shifts a programmed number of positions, reports busy while working, and pulses done when finished. It sits behind the same driver/monitor style interface: the write side drives control and data, the read side samples out.

Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1), width of the burst count port (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-high; clears all state.
- shift_en  in  1  single-step enable while not busy.
- mode  in  3  operation select (encoding below).
- data_in  in  WIDTH  parallel load data.
- sin_l  in  1  serial input entering at the MSB on SHR.
- sin_r  in  1  serial input entering at bit 0 on SHL.
- start  in  1  burst request.
- count  in  CNT_W  burst length in positions.
- out  out  WIDTH  register contents.
- sout_l  out  1  equals out[WIDTH-1], combinational from the register.
- sout_r  out  1  equals out[0], combinational from the register.
- busy  out  1  high while a burst is shifting.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Mode encoding (codes 0-3 match the legacy 2-bit sel encoding):
  - 0 HOLD.
  - 1 SHL: {out[W-2:0], sin_r}.
  - 2 SHR: {sin_l, out[W-1:1]}.
  - 3 LOAD: data_in.
  - 4 ROL: {out[W-2:0], out[W-1]}.
  - 5 ROR: {out[0], out[W-1:1]}.
  - 6 ASR: {out[W-1], out[W-1:1]}.
  - 7 reserved, behaves as HOLD.
- Reset: clr=1 at an edge forces out=0, busy=0, done=0, state IDLE, latched mode and count cleared. clr overrides every other input, including mid-burst; an aborted burst produces no done pulse.
- States:
  - IDLE: busy=0, done=0. Accepts inputs.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle. Accepts inputs exactly as IDLE does.
- Input acceptance in IDLE or DONE:
  - start=1 with mode in {1,2,4,5,6}: latch mode, latch remaining = min(count, WIDTH); out is unchanged at this edge.
    - If the clamped count is 0, go to DONE.
    - Otherwise go to RUN.
  - start=1 with mode in {0,3,7}: start is ignored and the shift_en rule applies.
  - start=0 and shift_en=1: apply mode once at this edge; next state IDLE.
  - start has priority over shift_en when both are high and the mode is valid.
  - Otherwise: hold; next state IDLE.
- RUN:
  - Each edge applies the latched mode once and decrements remaining.
  - The edge that performs the last shift moves to DONE.
  - The live mode, shift_en, start, count and data_in are all ignored. sin_l and sin_r are sampled live at every shift edge.
- Latency: a burst of N (1..WIDTH) gives busy high for N cycles starting at the edge after acceptance. The final value appears at acceptance+N edges, with done high during the following cycle.
- Width rules:
  - count values above WIDTH are clamped to WIDTH.
  - remaining is a CNT_W-bit down-counter and never underflows.
  - A rotate by WIDTH restores the original value.

Decomposition:
- Package usr_pkg holds:
  - the mode_e enum (3-bit, codes above);
  - the state_e enum (IDLE, RUN, DONE);
  - a helper to test whether a mode is burst-eligible.
- Sub-module usr_step: purely combinational next-value function, taking cur, mode, data_in, sin_l and sin_r and returning nxt. It is shared by the single-step path and the burst path.
- The top level holds the FSM, the counter and the register.

Test Plan (WIDTH=8):
- Reset: out=0xA5, then clr=1 for one edge -> out=0x00, busy=0, done=0. Also start=1 with clr=1 -> no burst is started.
- Single step: LOAD 0x96 -> out=0x96. Then SHL with sin_r=1 -> 0x2D. Then SHR with sin_l=0 -> 0x16. Check sout_l and sout_r track out[7] and out[0].
- ASR burst: out=0x90, start, mode=6, count=3 -> 0xC8, 0xE4, 0xF2 on successive edges. busy high for 3 cycles, then done=1 for 1 cycle. Toggling mode and shift_en during RUN has no effect.
- Rotate and clamp: out=0x81.
  - ROR with count=3 -> 0x30.
  - Reload 0x81, ROL with count=12 -> clamped to 8: busy for 8 cycles, final out=0x81.
- Abort: ROR burst with count=5, clr=1 on the 2nd busy cycle -> out=0x00, busy=0, done never asserted.
- Boundaries:
  - start with count=0 -> out unchanged, busy never high, done pulses once.
  - start with mode=LOAD -> treated as single step when shift_en=1, with no busy.
  - New start accepted during the DONE cycle -> back-to-back burst with busy reasserted on the next cycle.
